// File: rtl/weather_pkg.sv
// Shared constants, state encodings and the BCD helper for the sensor UART reporter.
// UART_PARITY_EN adds the parity state to the serializer encoding.
package weather_pkg;

   localparam logic [7:0] ASCII_T   = 8'h54;
   localparam logic [7:0] ASCII_EQ  = 8'h3D;
   localparam logic [7:0] ASCII_C   = 8'h43;
   localparam logic [7:0] ASCII_SP  = 8'h20;
   localparam logic [7:0] ASCII_H   = 8'h48;
   localparam logic [7:0] ASCII_PCT = 8'h25;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_0   = 8'h30;

   localparam int unsigned FRAME_LEN = 15;

   typedef enum logic [1:0] {StIdle, StConvert, StSend, StDone} seq_state_e;

   typedef enum logic [2:0] {
      TxIdle,
      TxStart,
      TxData,
`ifdef UART_PARITY_EN
      TxParity,
`endif
      TxStop
   } tx_state_e;

   // One double-dabble iteration on {hundreds, tens, units, binary}.
   function automatic logic [19:0] dabble_step(input logic [19:0] v);
      logic [19:0] r;
      r = v;
      for (int i = 0; i < 3; i++) begin
         if (r[8 + 4*i +: 4] >= 4'd5) begin
            r[8 + 4*i +: 4] = r[8 + 4*i +: 4] + 4'd3;
         end
      end
      return {r[18:0], 1'b0};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer with load/ready handshake; ready is also high in the last
// stop-bit cycle so a new byte follows with no idle gap. UART_PARITY_EN selects 8E1.
module uart_tx_byte
   import weather_pkg::*;
#(
   parameter int unsigned BIT_CYC = 868
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       load_in,
   input  logic [7:0] data_in,
   output logic       ready_out,
   output logic       tx_out
);

   localparam int unsigned CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_CYC - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
`ifdef UART_PARITY_EN
   logic             par_q, par_d;
`endif

   assign ready_out = (state_q == TxIdle) || ((state_q == TxStop) && (cnt_q == '0));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
`ifdef UART_PARITY_EN
      par_d   = par_q;
`endif
      tx_out  = 1'b1;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      unique case (state_q)
         TxIdle: ;
         TxStart: begin
            tx_out = 1'b0;
            if (cnt_q == '0) begin
               state_d = TxData;
               cnt_d   = RELOAD;
               bit_d   = 3'd0;
            end
         end
         TxData: begin
            tx_out = sh_q[0];
            if (cnt_q == '0) begin
               cnt_d = RELOAD;
               sh_d  = {1'b0, sh_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = TxParity;
`else
                  state_d = TxStop;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         TxParity: begin
            tx_out = par_q;
            if (cnt_q == '0) begin
               state_d = TxStop;
               cnt_d   = RELOAD;
            end
         end
`endif
         TxStop: begin
            if (cnt_q == '0) state_d = TxIdle;
         end
         default: state_d = TxIdle;
      endcase
      if (load_in && ready_out) begin
         state_d = TxStart;
         cnt_d   = RELOAD;
         sh_d    = data_in;
`ifdef UART_PARITY_EN
         par_d   = ^data_in;
`endif
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= TxIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
`ifdef UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
`ifdef UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: rtl/sensor_uart_reporter.sv
// Captures temperature/humidity on a sample_valid rising edge, converts both to BCD and
// sends "T=dddC H=ddd%\r\n" over UART. UART_PARITY_EN switches framing to 8E1.
module sensor_uart_reporter
   import weather_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       sample_valid_in,
   input  logic [7:0] temperature_in,
   input  logic [7:0] humidity_in,
   output logic       uart_tx_out,
   output logic       busy_out,
   output logic       frame_done_out
);

   localparam int unsigned BIT_CYC = CLK_HZ / BAUD;

   seq_state_e  state_q, state_d;
   logic        prev_q;
   logic        capture;
   logic [2:0]  cnv_q, cnv_d;
   logic [3:0]  idx_q, idx_d;
   logic [19:0] dd_t_q, dd_t_d, dd_h_q, dd_h_d;
   logic        pend_q, pend_d;
   logic [7:0]  pend_t_q, pend_t_d, pend_h_q, pend_h_d;
   logic        tx_load, tx_ready;
   logic [7:0]  tx_char;

   assign capture = sample_valid_in & ~prev_q;

   // Character for the current index; BCD digits sit in dd_*_q[19:8] once converted.
   always_comb begin
      case (idx_q)
         4'd0:    tx_char = ASCII_T;
         4'd1:    tx_char = ASCII_EQ;
         4'd2:    tx_char = ASCII_0 + {4'd0, dd_t_q[19:16]};
         4'd3:    tx_char = ASCII_0 + {4'd0, dd_t_q[15:12]};
         4'd4:    tx_char = ASCII_0 + {4'd0, dd_t_q[11:8]};
         4'd5:    tx_char = ASCII_C;
         4'd6:    tx_char = ASCII_SP;
         4'd7:    tx_char = ASCII_H;
         4'd8:    tx_char = ASCII_EQ;
         4'd9:    tx_char = ASCII_0 + {4'd0, dd_h_q[19:16]};
         4'd10:   tx_char = ASCII_0 + {4'd0, dd_h_q[15:12]};
         4'd11:   tx_char = ASCII_0 + {4'd0, dd_h_q[11:8]};
         4'd12:   tx_char = ASCII_PCT;
         4'd13:   tx_char = ASCII_CR;
         default: tx_char = ASCII_LF;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnv_d    = cnv_q;
      idx_d    = idx_q;
      dd_t_d   = dd_t_q;
      dd_h_d   = dd_h_q;
      pend_d   = pend_q;
      pend_t_d = pend_t_q;
      pend_h_d = pend_h_q;
      tx_load  = 1'b0;
      if (capture && (state_q != StIdle)) begin
         pend_d   = 1'b1;
         pend_t_d = temperature_in;
         pend_h_d = humidity_in;
      end
      unique case (state_q)
         StIdle: begin
            if (capture) begin
               dd_t_d  = {12'd0, temperature_in};
               dd_h_d  = {12'd0, humidity_in};
               cnv_d   = 3'd0;
               idx_d   = 4'd0;
               state_d = StConvert;
            end
         end
         StConvert: begin
            dd_t_d = dabble_step(dd_t_q);
            dd_h_d = dabble_step(dd_h_q);
            cnv_d  = cnv_q + 3'd1;
            // Character 0 is a constant, so it can be handed over during the last shift.
            if (cnv_q == 3'd7) begin
               tx_load = 1'b1;
               idx_d   = 4'd1;
               state_d = StSend;
            end
         end
         StSend: begin
            if (tx_ready) begin
               if (idx_q != 4'(FRAME_LEN)) begin
                  tx_load = 1'b1;
                  idx_d   = idx_q + 4'd1;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (pend_q || capture) begin
               dd_t_d  = {12'd0, capture ? temperature_in : pend_t_q};
               dd_h_d  = {12'd0, capture ? humidity_in : pend_h_q};
               pend_d  = 1'b0;
               cnv_d   = 3'd0;
               idx_d   = 4'd0;
               state_d = StConvert;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign frame_done_out = (state_q == StDone);
   assign busy_out       = (state_q != StIdle) &&
                           !((state_q == StDone) && !pend_q && !capture);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= StIdle;
         prev_q   <= 1'b0;
         cnv_q    <= '0;
         idx_q    <= '0;
         dd_t_q   <= '0;
         dd_h_q   <= '0;
         pend_q   <= 1'b0;
         pend_t_q <= '0;
         pend_h_q <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= sample_valid_in;
         cnv_q    <= cnv_d;
         idx_q    <= idx_d;
         dd_t_q   <= dd_t_d;
         dd_h_q   <= dd_h_d;
         pend_q   <= pend_d;
         pend_t_q <= pend_t_d;
         pend_h_q <= pend_h_d;
      end
   end

   uart_tx_byte #(
      .BIT_CYC (BIT_CYC)
   ) u_tx (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .load_in   (tx_load),
      .data_in   (tx_char),
      .ready_out (tx_ready),
      .tx_out    (uart_tx_out)
   );

endmodule

// File: tb/tb_sensor_uart_reporter.sv
// Bench for sensor_uart_reporter at a reduced bit period; a line-level UART receiver and a
// string-formatting model of the report supply the expected frames and timing.
module tb_sensor_uart_reporter;

   localparam int unsigned CLK_HZ = 1000;
   localparam int unsigned BAUD   = 100;
   localparam int unsigned B      = CLK_HZ / BAUD;
`ifdef UART_PARITY_EN
   localparam int unsigned CHAR_BITS = 11;
`else
   localparam int unsigned CHAR_BITS = 10;
`endif
   localparam int unsigned CHAR_CYC  = CHAR_BITS * B;
   localparam int unsigned FRAME_CYC = 15 * CHAR_CYC;

   typedef struct {
      logic [7:0]   t;
      logic [7:0]   h;
      logic [119:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sv = 1'b0;
   logic [7:0] temp = 8'd0;
   logic [7:0] hum = 8'd0;
   logic       tx, busy, fdone;

   sensor_uart_reporter #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .sample_valid_in (sv),
      .temperature_in  (temp),
      .humidity_in     (hum),
      .uart_tx_out     (tx),
      .busy_out        (busy),
      .frame_done_out  (fdone)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] rx_q[$];
   int         st_q[$];
   int         done_q[$];
   logic       done_busy_q[$];
   logic       par_q[$];
   int         frame_err = 0;
   int         par_err = 0;
   int         low_cnt = 0;
   int         n_cmp = 0;
   int         n_fail = 0;

   always @(negedge clk) begin
      if (fdone) begin
         done_q.push_back(cyc);
         done_busy_q.push_back(busy);
      end
      if (!tx) low_cnt <= low_cnt + 1;
   end

   // Line receiver: samples each bit at its midpoint, logs bytes and start-bit cycles.
   initial begin
      logic [7:0] b;
      int         st;
      forever begin
         @(negedge clk);
         if (!rst && !tx) begin
            st = cyc;
            b  = 8'd0;
            repeat (B / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (B) @(negedge clk);
               b[i] = tx;
            end
`ifdef UART_PARITY_EN
            repeat (B) @(negedge clk);
            par_q.push_back(tx);
            if (tx != ^b) par_err++;
`endif
            repeat (B) @(negedge clk);
            if (!tx) frame_err++;
            rx_q.push_back(b);
            st_q.push_back(st);
         end
      end
   end

   function automatic logic [119:0] model_frame(input int t, input int h);
      return {"T=", 8'(48 + t / 100), 8'(48 + (t / 10) % 10), 8'(48 + t % 10), "C H=",
              8'(48 + h / 100), 8'(48 + (h / 10) % 10), 8'(48 + h % 10), "%\r\n"};
   endfunction

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic check_frame(input string name, input int base, input logic [119:0] exp);
      int bad;
      bad = -1;
      n_cmp++;
      if (rx_q.size() < base + 15) begin
         n_fail++;
         $display("FAIL %s: %0d bytes received, want %0d", name, rx_q.size(), base + 15);
         return;
      end
      for (int i = 0; i < 15; i++) begin
         if (bad < 0 && rx_q[base + i] != exp[119 - 8*i -: 8]) bad = i;
      end
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: char %0d got %02h, want %02h", name, bad, rx_q[base + bad],
                  exp[119 - 8*bad -: 8]);
      end
   endtask

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   endtask

   task automatic wait_done(input int n);
      int k;
      k = 0;
      while (done_q.size() < n && k < 3 * FRAME_CYC) begin
         @(posedge clk);
         k++;
      end
      if (done_q.size() < n) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_done: %0d frames seen, want %0d", done_q.size(), n);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
         $fatal(1, "frame timeout");
      end
   endtask

   task automatic wait_cyc(input int target);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < target);
   endtask

   // One-cycle pulse on sample_valid; c is the cycle in which the edge is seen.
   task automatic send_sample(input logic [7:0] t, input logic [7:0] h, output int c);
      @(posedge clk);
      #1;
      temp = t;
      hum  = h;
      sv   = 1'b1;
      c    = cyc;
      @(posedge clk);
      #1;
      sv = 1'b0;
   endtask

   vec_t vecs[10];
   int   nf;
   int   c;
   int   rc;
   int   lc;
   int   d;

   initial begin
      vecs[0] = '{8'd23, 8'd45, "T=023C H=045%\r\n"};
      vecs[1] = '{8'd255, 8'd0, "T=255C H=000%\r\n"};
      vecs[2] = '{8'd0, 8'd255, "T=000C H=255%\r\n"};
      vecs[3] = '{8'd100, 8'd9, "T=100C H=009%\r\n"};
      vecs[4] = '{8'd199, 8'd90, "T=199C H=090%\r\n"};
      for (int i = 5; i < 10; i++) begin
         vecs[i].t   = 8'($urandom_range(0, 255));
         vecs[i].h   = 8'($urandom_range(0, 255));
         vecs[i].exp = model_frame(int'(vecs[i].t), int'(vecs[i].h));
      end

      #12;
      check("reset tx", int'(tx), 1);
      check("reset busy", int'(busy), 0);
      check("reset frame_done", int'(fdone), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("idle tx", int'(tx), 1);

      nf = 0;
      for (int i = 0; i < 10; i++) begin
         send_sample(vecs[i].t, vecs[i].h, c);
         check($sformatf("vec%0d busy at C+1", i), int'(busy), 1);
         wait_done(nf + 1);
         check_frame($sformatf("vec%0d frame", i), nf * 15, vecs[i].exp);
         check($sformatf("vec%0d start", i), st_q[nf * 15], c + 9);
         check($sformatf("vec%0d done", i), done_q[nf], st_q[nf * 15] + FRAME_CYC);
         check($sformatf("vec%0d busy at done", i), int'(done_busy_q[nf]), 0);
         nf++;
         repeat (7) @(posedge clk);
      end

      // Held-high level produces exactly one frame.
      @(posedge clk);
      #1;
      temp = 8'd77;
      hum  = 8'd88;
      sv   = 1'b1;
      c    = cyc;
      repeat (3 * FRAME_CYC) begin
         @(posedge clk);
         #1;
         temp = 8'($urandom);
         hum  = 8'($urandom);
      end
      sv = 1'b0;
      repeat (10) @(posedge clk);
      check("held frames", done_q.size(), nf + 1);
      check("held bytes", rx_q.size(), (nf + 1) * 15);
      check_frame("held frame", nf * 15, model_frame(77, 88));
      check("held start", st_q[nf * 15], c + 9);
      nf++;

      // Two edges mid-frame: the later one wins, the frame in flight is untouched.
      send_sample(8'd23, 8'd45, c);
      wait_cyc(c + 9 + 3 * CHAR_CYC);
      send_sample(8'd30, 8'd60, d);
      wait_cyc(c + 9 + 10 * CHAR_CYC);
      send_sample(8'd31, 8'd61, d);
      wait_done(nf + 2);
      check_frame("pend first frame", nf * 15, model_frame(23, 45));
      check("pend busy at done", int'(done_busy_q[nf]), 1);
      check("pend second start", st_q[(nf + 1) * 15], done_q[nf] + 9);
      check_frame("pend second frame", (nf + 1) * 15, model_frame(31, 61));
      repeat (2 * FRAME_CYC) @(posedge clk);
      check("pend frame count", done_q.size(), nf + 2);
      nf += 2;

      // Edge landing exactly in the DONE cycle.
      send_sample(8'd7, 8'd8, c);
      d = c + 9 + FRAME_CYC;
      wait_cyc(d);
      temp = 8'd200;
      hum  = 8'd150;
      sv   = 1'b1;
      @(posedge clk);
      #1;
      sv = 1'b0;
      wait_done(nf + 2);
      check("donecap done cycle", done_q[nf], d);
      check("donecap busy at done", int'(done_busy_q[nf]), 1);
      check("donecap second start", st_q[(nf + 1) * 15], d + 9);
      check_frame("donecap second frame", (nf + 1) * 15, model_frame(200, 150));
      nf += 2;
      repeat (20) @(posedge clk);

      check("stop bit errors", frame_err, 0);
`ifdef UART_PARITY_EN
      check("parity errors", par_err, 0);
      check("parity of first T", int'(par_q[0]), 1);
`endif

      // Reset during character 5.
      rc = rx_q.size();
      send_sample(8'd12, 8'd34, c);
      wait_cyc(c + 9 + 5 * CHAR_CYC + 3 * B);
      rst = 1'b1;
      #1;
      check("midreset tx", int'(tx), 1);
      check("midreset busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2 * CHAR_CYC) @(posedge clk);
      check("midreset bytes", rx_q.size(), rc + 6);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("midreset char%0d", i), int'(rx_q[rc + i]),
               int'(model_frame(12, 34) >> (112 - 8 * i)) & 8'hFF);
      end
      lc = low_cnt;
      rc = rx_q.size();
      repeat (2 * FRAME_CYC) @(posedge clk);
      check("midreset line quiet", low_cnt, lc);
      check("midreset no bytes", rx_q.size(), rc);
      check("midreset no done", done_q.size(), nf);

      finish_run();
   end

endmodule

// File: doc/sensor_uart_reporter.md
# sensor_uart_reporter

Downstream consumer of the DHT11 reader's output. On each completed sensor transfer it latches the 8-bit temperature and humidity readings and converts them to three decimal digits each. It then transmits a fixed 15-character ASCII report over an 8N1 UART, `T=ddd C H=ddd%\r\n` without the space before C, e.g. "T=023C H=045%\r\n". It sits beside the display path and taps the same `temperature`, `humidity` and `transfer_done` nets.

## Interface
- CLK_HZ, 100_000_000, input clock frequency in Hz
- BAUD, 115200, UART bit rate; bit period BIT_CYC = CLK_HZ/BAUD, integer truncated (868 at defaults)
- clk_in  input  1  system clock, 100 MHz
- rst_in  input  1  asynchronous, active-high reset
- sample_valid_in  input  1  transfer-done indication from the DHT11 reader; level or pulse, rising edge significant
- temperature_in  input  8  binary temperature, 0..255
- humidity_in  input  8  binary humidity, 0..255
- uart_tx_out  output  1  serial line, idle high
- busy_out  output  1  high from capture until the last stop bit ends
- frame_done_out  output  1  one-cycle pulse after the final character's stop bit

## Operation
- Reset values:
  - uart_tx_out=1, busy_out=0, frame_done_out=0
  - pending flag, latched values, state and counters all cleared
- Edge detect:
  - sample_valid_in is compared against its registered previous value.
  - A capture event occurs in a cycle where in=1 and prev=0.
  - A held-high level never retriggers.
- States: IDLE, CONVERT, START, DATA, PARITY (macro only), STOP, DONE.
- IDLE + capture event:
  - latch temperature_in and humidity_in
  - busy_out=1
  - go to CONVERT
- CONVERT:
  - double-dabble both bytes in parallel, one shift per cycle, 8 cycles
  - produces T2 T1 T0 and H2 H1 H0 in BCD
  - char index=0, then go to START
- Character sequence, index 0..14:
  - 'T' '=' T2 T1 T0 'C' ' ' 'H' '=' H2 H1 H0 '%' CR LF
  - digits are 0x30+BCD
- Serializer:
  - START drives 0 for BIT_CYC cycles.
  - DATA sends 8 bits LSB first, BIT_CYC cycles each.
  - STOP drives 1 for BIT_CYC cycles.
  - After STOP, if index<14: index+1, go to START. Otherwise go to DONE.
- DONE (one cycle):
  - frame_done_out=1
  - if pending: clear pending, load pending values, go to CONVERT
  - otherwise busy_out=0, go to IDLE
- Capture event while busy:
  - pending=1, and pending values are overwritten with the current inputs
  - only the latest sample is retained; the frame in flight is never altered
- Capture event in the DONE cycle itself is treated as pending and is served immediately.
- Reset mid-frame:
  - line returns high asynchronously
  - partial frame abandoned, pending discarded

## Timing
- Latencies, with C = the cycle the capture event is registered:
  - CONVERT occupies C+1..C+8
  - start bit of character 0 begins at C+9
- Character length: 10×BIT_CYC cycles, or 11×BIT_CYC with parity.
- Frame length: 150×BIT_CYC (130200 cycles at defaults), or 165×BIT_CYC (143220) with parity.
- frame_done_out is asserted one cycle after the last stop bit period ends; busy_out falls in the same cycle.
- Characters are back-to-back, with no idle gap between one stop bit and the next start bit.
- The bit counter reloads to BIT_CYC-1 at each bit boundary; there is no fractional-baud correction.

## Configuration
- UART_PARITY_EN defined:
  - a PARITY state is inserted between DATA and STOP
  - it drives even parity (XOR of the 8 data bits) for BIT_CYC cycles
  - framing becomes 8E1
- UART_PARITY_EN undefined:
  - PARITY state and logic are absent
  - framing is 8N1

## Structure
- Shared package weather_pkg holds:
  - ASCII constants for T, =, C, space, H, %, CR, LF, and '0'
  - FRAME_LEN=15
  - the state enumeration
- Sub-module uart_tx_byte:
  - performs baud counting and START/DATA/[PARITY]/STOP serialization of one byte
  - handshake: load/ready
  - the parent handles sequencing, BCD conversion and pending logic

## Test plan
- temp=23, hum=45, single pulse:
  - bytes 54 3D 30 32 33 43 20 48 3D 30 34 35 25 0D 0A
  - start bit at C+9
  - frame_done pulse 130200 cycles after the start bit
- temp=255, hum=0: sends "T=255C H=000%\r\n".
- sample_valid_in held high for 200000 cycles: exactly one frame is sent.
- Second edge mid-frame with (30,60), third edge with (31,61) before the first frame ends:
  - the first frame is unchanged
  - exactly one more frame follows, carrying 031/061
- rst_in asserted during character 5: uart_tx_out=1 and busy_out=0 immediately, and no further bits are sent.
- UART_PARITY_EN defined, temp=23: the first character 0x54 carries parity bit 1, and the frame lasts 143220 cycles.
